// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds word alignment via bitslip on control-token runs,
// then decodes 10-bit symbols to pixel bytes or {C1,C0} control values.
module tmds_channel_decoder #(
   parameter int LOCK_TOKENS   = 8,
   parameter int SEARCH_WINDOW = 1024,
   parameter int SLIP_WAIT     = 16
) (
   input  logic       clk_pixel,
   input  logic       rst_n,
   input  logic [9:0] tmds_word,
   output logic       bitslip,
   output logic [3:0] slip_count,
   output logic       locked,
   output logic       de,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic [1:0] state_dbg
);
   localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
   localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
   localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_TOKENS);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_WAIT   = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [RUN_W-1:0]    run, run_nx, run_step;
   logic [WIN_W-1:0]    win, win_nx;
   logic [WAIT_W-1:0]   wait_cnt, wait_nx;
   logic [3:0]          slip_nx;
   logic                bitslip_nx;
   logic                locked_nx;
   logic                run_done;
   logic                is_ctrl;
   logic [1:0]          tok;
   logic [7:0]          q;
   logic [7:0]          dec;

   assign state_dbg = state;

   always_comb begin
      is_ctrl = 1'b1;
      tok     = 2'b00;
      case (tmds_word)
         10'h354: tok = 2'b00;
         10'h0AB: tok = 2'b01;
         10'h154: tok = 2'b10;
         10'h2AB: tok = 2'b11;
         default: is_ctrl = 1'b0;
      endcase
   end

   // TMDS stage-1 inverse: undo optional inversion, then XOR/XNOR chain.
   always_comb begin
      q      = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0];
      dec    = 8'h00;
      dec[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = tmds_word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_SEARCH;
         run        <= '0;
         win        <= '0;
         wait_cnt   <= '0;
         slip_count <= 4'd0;
         bitslip    <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state      <= state_nx;
         run        <= run_nx;
         win        <= win_nx;
         wait_cnt   <= wait_nx;
         slip_count <= slip_nx;
         bitslip    <= bitslip_nx;
         locked     <= locked_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      run_nx     = run;
      win_nx     = win;
      wait_nx    = wait_cnt;
      slip_nx    = slip_count;
      bitslip_nx = 1'b0;
      run_step   = is_ctrl ? ((run == RUN_MAX) ? RUN_MAX : run + 1'b1) : '0;
      run_done   = (run_step == RUN_MAX);
      case (state)
         S_SEARCH: begin
            run_nx = run_step;
            // A completed run takes priority over window expiry on the same cycle.
            if (run_done) begin
               state_nx = S_LOCKED;
               win_nx   = '0;
            end else if (win == WIN_LAST) begin
               state_nx   = S_WAIT;
               bitslip_nx = 1'b1;
               slip_nx    = (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
               run_nx     = '0;
               win_nx     = '0;
               wait_nx    = '0;
            end else begin
               win_nx = win + 1'b1;
            end
         end
         S_WAIT: begin
            run_nx = '0;
            win_nx = '0;
            if (wait_cnt == WAIT_LAST) begin
               state_nx = S_SEARCH;
               wait_nx  = '0;
            end else begin
               wait_nx = wait_cnt + 1'b1;
            end
         end
         S_LOCKED: begin
            run_nx = run_step;
            if (run_done) begin
               win_nx = '0;
            end else if (win == WIN_LAST) begin
               state_nx = S_SEARCH;
               slip_nx  = 4'd0;
               run_nx   = '0;
               win_nx   = '0;
            end else begin
               win_nx = win + 1'b1;
            end
         end
         default: begin
            state_nx = S_SEARCH;
            run_nx   = '0;
            win_nx   = '0;
            wait_nx  = '0;
         end
      endcase
      locked_nx = (state_nx == S_LOCKED);
   end

   // Output stage is qualified by the lock value being written on the same edge.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         de   <= 1'b0;
         data <= 8'h00;
         ctrl <= 2'b00;
      end else if (locked_nx && is_ctrl) begin
         de   <= 1'b0;
         data <= 8'h00;
         ctrl <= tok;
      end else if (locked_nx) begin
         de   <= 1'b1;
         data <= dec;
      end else begin
         de   <= 1'b0;
         data <= 8'h00;
      end
   end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, slip search, lock loss, async reset.
module tb_tmds_channel_decoder;
   logic       clk_pixel = 1'b0;
   logic       rst_n     = 1'b0;
   logic [9:0] tmds_word = 10'h000;
   logic       bitslip;
   logic [3:0] slip_count;
   logic       locked;
   logic       de;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic [1:0] state_dbg;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk_pixel = ~clk_pixel;

   tmds_channel_decoder dut (
      .clk_pixel  (clk_pixel),
      .rst_n      (rst_n),
      .tmds_word  (tmds_word),
      .bitslip    (bitslip),
      .slip_count (slip_count),
      .locked     (locked),
      .de         (de),
      .data       (data),
      .ctrl       (ctrl),
      .state_dbg  (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic [9:0] w);
      tmds_word = w;
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      tmds_word = 10'h000;
      repeat (3) @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
   endtask

   // Transmit stream: 160 blanking tokens then 640 alternating data words.
   function automatic logic [9:0] stream_sym(input int phase);
      if (phase < 160) return 10'h354;
      return ((phase % 2) == 1) ? 10'h0FF : 10'h100;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int nslip;
      int de_cnt;
      int npulse;
      int last_pulse;
      int close_cnt;
      int double_cnt;
      int offset;
      int phase;
      logic last_high;
      logic [9:0]  prev_sym;
      logic [9:0]  cur_sym;
      logic [19:0] shifted;
      logic [7:0]  exp_b;

      // Reset state
      do_reset();
      check("rst_bitslip", bitslip, 0);
      check("rst_slip_count", slip_count, 0);
      check("rst_locked", locked, 0);
      check("rst_de", de, 0);
      check("rst_data", data, 8'h00);
      check("rst_ctrl", ctrl, 2'b00);
      check("rst_state", state_dbg, 2'd0);

      // Aligned stream: lock on the 8th token
      nslip = 0;
      bad   = 0;
      for (int k = 1; k <= 7; k++) begin
         tick(10'h354);
         if (locked !== 1'b0) bad++;
      end
      check("no_lock_before_8", bad, 0);
      tick(10'h354);
      check("lock_on_8th", locked, 1);
      check("lock_de", de, 0);
      check("lock_ctrl", ctrl, 2'b00);
      check("lock_state", state_dbg, 2'd2);
      for (int k = 0; k < 152; k++) begin
         tick(10'h354);
         if (bitslip) nslip++;
      end
      tick(10'h100);
      check("data_100_de", de, 1);
      check("data_100_val", data, 8'h00);
      tick(10'h0FF);
      check("data_0ff_de", de, 1);
      check("data_0ff_val", data, 8'hFF);
      bad = 0;
      for (int j = 2; j < 640; j++) begin
         tick(((j % 2) == 1) ? 10'h0FF : 10'h100);
         exp_b = ((j % 2) == 1) ? 8'hFF : 8'h00;
         if (de !== 1'b1 || data !== exp_b) bad++;
         if (bitslip) nslip++;
      end
      check("aligned_data_run", bad, 0);
      for (int k = 0; k < 20; k++) begin
         tick(10'h354);
         if (bitslip) nslip++;
      end
      check("aligned_still_locked", locked, 1);
      check("aligned_no_bitslip", nslip, 0);

      // Control decode while locked
      tick(10'h0AB);
      check("ctrl_01", ctrl, 2'b01);
      check("ctrl_01_de", de, 0);
      check("ctrl_01_data", data, 8'h00);
      tick(10'h154);
      check("ctrl_10", ctrl, 2'b10);
      tick(10'h2AB);
      check("ctrl_11", ctrl, 2'b11);
      check("ctrl_11_de", de, 0);
      tick(10'h100);
      check("ctrl_hold_de", de, 1);
      check("ctrl_hold_a", ctrl, 2'b11);
      tick(10'h0FF);
      check("ctrl_hold_b", ctrl, 2'b11);
      check("ctrl_hold_data", data, 8'hFF);

      // Hand-decoded data words
      tick(10'h2AA);
      check("dec_2aa", data, 8'h01);
      tick(10'h1F0);
      check("dec_1f0", data, 8'h10);
      tick(10'h3C3);
      check("dec_3c3", data, 8'h44);
      tick(10'h05A);
      check("dec_05a", data, 8'h10);

      // Loss of lock: last completed run, then data only
      for (int k = 0; k < 10; k++) tick(10'h354);
      check("pre_loss_ctrl", ctrl, 2'b00);
      bad = 0;
      for (int j = 1; j <= 1023; j++) begin
         tick(10'h100);
         if (locked !== 1'b1) bad++;
      end
      check("loss_hold_locked", bad, 0);
      check("loss_last_de", de, 1);
      tick(10'h100);
      check("loss_locked", locked, 0);
      check("loss_de", de, 0);
      check("loss_data", data, 8'h00);
      check("loss_slip_count", slip_count, 0);
      check("loss_ctrl_hold", ctrl, 2'b00);
      check("loss_no_slip", bitslip, 0);
      nslip = 0;
      for (int j = 1025; j <= 2047; j++) begin
         tick(10'h100);
         if (bitslip) nslip++;
      end
      check("loss_quiet_window", nslip, 0);
      tick(10'h100);
      check("loss_slip_pulse", bitslip, 1);
      check("loss_slip_count1", slip_count, 1);
      check("wait_state", state_dbg, 2'd1);

      // Async reset mid-pulse / mid-WAIT
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_wait_bitslip", bitslip, 0);
      check("arst_wait_slip_count", slip_count, 0);
      check("arst_wait_state", state_dbg, 2'd0);
      repeat (3) @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 1; k <= 7; k++) begin
         tick(10'h354);
         if (locked !== 1'b0) bad++;
      end
      tick(10'h354);
      check("relock_a_early", bad, 0);
      check("relock_a", locked, 1);
      tick(10'h2AB);
      tick(10'h3C3);
      check("pre_arst_de", de, 1);
      check("pre_arst_data", data, 8'h44);
      check("pre_arst_ctrl", ctrl, 2'b11);

      // Async reset mid-LOCKED
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_lock_locked", locked, 0);
      check("arst_lock_de", de, 0);
      check("arst_lock_data", data, 8'h00);
      check("arst_lock_ctrl", ctrl, 2'b00);
      repeat (3) @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) tick(10'h354);
      check("relock_b_7", locked, 0);
      tick(10'h354);
      check("relock_b_8", locked, 1);

      // Broken run: never 8 consecutive tokens, slip at end of window
      do_reset();
      bad   = 0;
      nslip = 0;
      for (int t = 1; t <= 1023; t++) begin
         if (t <= 7 || (t >= 9 && t <= 15)) tick(10'h354);
         else tick(10'h100);
         if (locked !== 1'b0) bad++;
         if (bitslip) nslip++;
      end
      check("broken_no_lock", bad, 0);
      check("broken_no_early_slip", nslip, 0);
      tick(10'h100);
      check("broken_slip", bitslip, 1);
      check("broken_slip_count", slip_count, 1);
      check("broken_locked", locked, 0);
      tick(10'h100);
      check("broken_slip_single", bitslip, 0);

      // Misalignment: deserializer model offset by 3 bits
      do_reset();
      offset     = 3;
      phase      = 0;
      prev_sym   = 10'h000;
      cur_sym    = 10'h000;
      npulse     = 0;
      last_pulse = 0;
      close_cnt  = 0;
      double_cnt = 0;
      last_high  = 1'b0;
      for (int t = 1; t <= 12000 && !locked; t++) begin
         prev_sym = cur_sym;
         cur_sym  = stream_sym(phase);
         phase    = (phase + 1) % 800;
         shifted  = {cur_sym, prev_sym} >> offset;
         tick(shifted[9:0]);
         if (bitslip) begin
            if (last_high) double_cnt++;
            if (npulse > 0 && (t - last_pulse) < 1040) close_cnt++;
            npulse++;
            last_pulse = t;
            offset = (offset + 1) % 10;
         end
         last_high = bitslip;
      end
      check("mis_locked", locked, 1);
      check("mis_pulses", npulse, 7);
      check("mis_spacing", close_cnt, 0);
      check("mis_single_cycle", double_cnt, 0);
      check("mis_slip_count", slip_count, 7);
      de_cnt = 0;
      bad    = 0;
      nslip  = 0;
      for (int t = 0; t < 800; t++) begin
         prev_sym = cur_sym;
         cur_sym  = stream_sym(phase);
         phase    = (phase + 1) % 800;
         shifted  = {cur_sym, prev_sym} >> offset;
         tick(shifted[9:0]);
         if (bitslip) nslip++;
         if (de === 1'b1) begin
            de_cnt++;
            exp_b = (prev_sym == 10'h0FF) ? 8'hFF : 8'h00;
            if (prev_sym == 10'h354 || data !== exp_b) bad++;
         end
      end
      check("mis_de_count", de_cnt, 640);
      check("mis_data", bad, 0);
      check("mis_no_slip_locked", nslip, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
